// File: rtl/cam2ram_writer.sv
// Captures one YUYV camera frame on request, crops a W x H window and writes
// 3-bit grey (Y[7:5]) sequentially into the frame RAM on the pixel clock.
module cam2ram_writer #(
  parameter int unsigned X0 = 220,
  parameter int unsigned Y0 = 140,
  parameter int unsigned W  = 200,
  parameter int unsigned H  = 200
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  input  logic        cap_req,
  output logic        wrclk,
  output logic [15:0] wraddr,
  output logic [2:0]  wrdata,
  output logic        wren,
  output logic        busy,
  output logic        cap_done,
  output logic        frame_ok
);

  localparam logic [15:0] WH     = 16'(W * H);
  localparam logic [9:0]  COL_LO = 10'(X0);
  localparam logic [9:0]  COL_HI = 10'(X0 + W);
  localparam logic [8:0]  ROW_LO = 9'(Y0);
  localparam logic [8:0]  ROW_HI = 9'(Y0 + H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state;
  logic        vsync_d;
  logic        href_d;
  logic [10:0] bcnt;
  logic [8:0]  row;
  logic [15:0] wcnt;

  logic        fs;
  logic        fe;
  logic        le;
  logic [9:0]  col;
  logic        in_win;
  logic        qualify;
  logic [15:0] wcnt_nxt;
  logic        unused_din;

  assign wrclk = pclk;

  assign fs  = vsync_d & ~vsync;
  assign fe  = ~vsync_d & vsync;
  assign le  = href_d & ~href;
  assign col = bcnt[10:1];

  assign in_win = (col >= COL_LO) && (col < COL_HI) &&
                  (row >= ROW_LO) && (row < ROW_HI);

  // Only luma bytes inside the window count, and never more than W*H of them.
  assign qualify  = (state == S_CAPTURE) && href && !bcnt[0] && in_win && (wcnt < WH);
  assign wcnt_nxt = qualify ? wcnt + 16'd1 : wcnt;

  assign unused_din = ^din[4:0];

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= S_IDLE;
      vsync_d  <= 1'b1;
      href_d   <= 1'b0;
      bcnt     <= '0;
      row      <= '0;
      wcnt     <= '0;
      wraddr   <= '0;
      wrdata   <= '0;
      wren     <= 1'b0;
      busy     <= 1'b0;
      cap_done <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      vsync_d  <= vsync;
      href_d   <= href;
      wren     <= 1'b0;
      cap_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cap_req) begin
            state    <= S_ARMED;
            busy     <= 1'b1;
            wcnt     <= '0;
            frame_ok <= 1'b0;
          end
        end

        // An fs coinciding with the accepting cap_req was seen in IDLE, so it is skipped.
        S_ARMED: begin
          if (fs) begin
            state <= S_CAPTURE;
            bcnt  <= '0;
            row   <= '0;
          end
        end

        S_CAPTURE: begin
          if (le) begin
            bcnt <= '0;
            if (row != '1) row <= row + 9'd1;
          end else if (href && (bcnt != '1)) begin
            bcnt <= bcnt + 11'd1;
          end

          if (qualify) begin
            wren   <= 1'b1;
            wrdata <= din[7:5];
            wraddr <= wcnt;
            wcnt   <= wcnt_nxt;
          end

          // Outputs registered here so they are visible during the DONE cycle.
          if (fe) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            cap_done <= 1'b1;
            frame_ok <= (wcnt_nxt == WH);
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam2ram_writer.md
Name: cam2ram_writer

Overview:
- Captures one 8-bit YUYV camera frame (640x480) on request.
- Crops a 200x200 window and writes 3-bit grey (Y[7:5]) into the 40000-entry frame RAM.
- This is the same RAM that the VGA display path reads (16-bit address, 3-bit data).
- Sits between the camera port and the RAM write port; one instance per eye. The controller issues cap_req to both instances together.

Parameters:
- X0, 220, first captured pixel column (pixel units, 0..639)
- Y0, 140, first captured line (0..479)
- W, 200, window width in pixels
- H, 200, window height in lines

Ports:
- pclk  input  1  camera pixel clock; the only clock
- rst  input  1  synchronous, active-high reset
- vsync  input  1  camera vsync; high = vertical blanking
- href  input  1  camera line valid; high while bytes of a line are on din
- din  input  8  camera data, one byte per pclk while href=1; byte order Y0 U Y1 V ...
- cap_req  input  1  one-cycle capture request
- wrclk  output  1  RAM write clock; wired directly to pclk
- wraddr  output  16  RAM write address
- wrdata  output  3  RAM write data
- wren  output  1  RAM write enable
- busy  output  1  high in ARMED or CAPTURE
- cap_done  output  1  one-cycle pulse at end of capture
- frame_ok  output  1  valid with cap_done; 1 iff exactly W*H writes occurred

Behaviour:
- Reset (rst=1 at a pclk edge) forces:
  - wraddr=0, wrdata=0, wren=0, busy=0, cap_done=0, frame_ok=0.
  - State=IDLE; all counters 0; vsync_d=1, href_d=0.
  - Applies mid-capture too: the partial frame is abandoned and no cap_done is issued.
- Edge detection, on registered copies vsync_d and href_d:
  - fs (frame start) = vsync_d & ~vsync.
  - fe (frame end) = ~vsync_d & vsync.
  - le (line end) = href_d & ~href.
- Counters, active in CAPTURE only:
  - bcnt (11 bit): increments on every pclk with href=1; cleared on le.
  - row (9 bit): increments on le; saturates at 511.
  - Pixel column = bcnt>>1. A byte is luma when bcnt[0]=0.
  - bcnt and row are cleared on entry to CAPTURE.
- State machine:
  - IDLE -> ARMED on cap_req=1.
  - ARMED -> CAPTURE on fs. An fs in the same cycle as the accepting cap_req does not count; ARMED waits for the next fs.
  - CAPTURE -> DONE on fe.
  - DONE -> IDLE after exactly one cycle.
  - cap_req outside IDLE is ignored; no queueing.
- Write rule, in CAPTURE:
  - A byte qualifies when href=1, bcnt[0]=0, X0 <= bcnt>>1 < X0+W, Y0 <= row < Y0+H, and wcnt < W*H.
  - On a qualifying byte, at the next edge: wren=1, wrdata=din[7:5], wraddr=wcnt, wcnt<=wcnt+1. Latency is one pclk from byte to write.
  - Otherwise wren=0 at the next edge; wraddr and wrdata hold their previous values.
  - wcnt (16 bit) is cleared on entry to ARMED.
  - Addresses are written strictly sequentially, 0..W*H-1, row-major.
  - Bytes beyond wcnt=W*H (over-long frame) are dropped; the address never exceeds W*H-1 (39999).
- DONE cycle:
  - cap_done=1.
  - frame_ok=(wcnt==W*H).
  - frame_ok holds its value until the next cap_req is accepted, then clears.
- busy=1 in ARMED and CAPTURE; 0 in IDLE and DONE.
- Short frame (fe before 40000 writes): goes to DONE with frame_ok=0. RAM contents beyond wcnt are stale.
- href glitch with no luma byte: no write occurs; le still advances row.
- Lines longer than 640 px: the column-range check excludes the extra bytes; bcnt must not wrap within 1280 bytes.

Test Plan:
- Reset then idle, with frames running and no cap_req -> wren stays 0 for 2 full frames; busy=0; cap_done never pulses.
- cap_req, then a full 640x480 frame where Y byte = (x+y)&0xFF -> exactly 40000 wren pulses.
  - First write: wraddr=0, wrdata=(220+140)[7:5]=3'b011.
  - Last write: wraddr=39999 for pixel (419,339).
  - cap_done pulses once at fe; frame_ok=1.
- cap_req coincident with fs -> that frame is not captured; capture begins at the following fs (check the first wren timing).
- Short frame, vsync rises after line 240 -> 20000 writes (wraddr 0..19999); cap_done=1 with frame_ok=0.
- rst asserted mid-capture at wcnt=1000 -> next cycle wren=0, busy=0, wraddr=0; no cap_done. A new cap_req then captures from wraddr=0.
- Second cap_req during CAPTURE -> ignored; a single cap_done results. Long lines (700 px) -> still 200 writes per window line.
